// File: rtl/morse_pkg.sv
// morse_pkg: shared constants, state type and code-word builder for the
// Morse keyer. A code word is five 2-bit symbols. The first symbol to key
// sits in bits [1:0]. Unused trailing symbols are filled with SYM_END.
package morse_pkg;

  // Symbol encodings inside a 10-bit code word
  localparam logic [1:0] SYM_DOT  = 2'b01;
  localparam logic [1:0] SYM_DASH = 2'b10;
  localparam logic [1:0] SYM_END  = 2'b11;

  // All-ones word marks a character with no Morse representation
  localparam logic [9:0] CODE_INVALID = 10'h3FF;

  // Element lengths in Morse time units
  localparam int DOT_UNITS     = 1;
  localparam int DASH_UNITS    = 3;
  localparam int SPACE_UNITS   = 1;
  localparam int CHARGAP_UNITS = 3;
  localparam int WORDGAP_UNITS = 4;

  // Longest single timed interval, used to size the unit counter
  localparam int MAX_UNITS = 4;

  localparam logic [7:0] ASCII_SPACE = 8'h20;

  // Keying sequencer states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MARK,
    ST_SPACE,
    ST_CHARGAP,
    ST_WORDGAP
  } morse_state_e;

  // Builds a code word from a symbol count and a dot/dash pattern written
  // in reading order: pat[len-1] is the first symbol keyed, and 1 = dash.
  // The word is assembled last-symbol-first so the first symbol ends up in
  // bits [1:0].
  function automatic logic [9:0] build_code(input int len, input logic [4:0] pat);
    logic [9:0] code;
    logic [4:0] shifted;
    logic [1:0] sym;
    code = CODE_INVALID;
    for (int i = 4; i >= 0; i--) begin
      sym = SYM_END;
      if (i < len) begin
        shifted = pat >> (len - 1 - i);
        sym = shifted[0] ? SYM_DASH : SYM_DOT;
      end
      code = {code[7:0], sym};
    end
    return code;
  endfunction

endpackage

// File: rtl/morse_lut.sv
// morse_lut: combinational ASCII to Morse code-word lookup covering the
// digits 0-9 and the upper-case letters A-Z (International Morse). Any
// other byte, including space, returns CODE_INVALID. Space is
// handled by the sequencer before this table is consulted.
module morse_lut
  import morse_pkg::*;
(
  input  logic [7:0] ascii,
  output logic [9:0] code
);

  // Table lookup; patterns read left to right, 1 = dash, 0 = dot
  always_comb begin
    code = CODE_INVALID;
    case (ascii)
      8'h30: code = build_code(5, 5'b11111); // 0 -----
      8'h31: code = build_code(5, 5'b01111); // 1 .----
      8'h32: code = build_code(5, 5'b00111); // 2 ..---
      8'h33: code = build_code(5, 5'b00011); // 3 ...--
      8'h34: code = build_code(5, 5'b00001); // 4 ....-
      8'h35: code = build_code(5, 5'b00000); // 5 .....
      8'h36: code = build_code(5, 5'b10000); // 6 -....
      8'h37: code = build_code(5, 5'b11000); // 7 --...
      8'h38: code = build_code(5, 5'b11100); // 8 ---..
      8'h39: code = build_code(5, 5'b11110); // 9 ----.
      8'h41: code = build_code(2, 5'b00001); // A .-
      8'h42: code = build_code(4, 5'b01000); // B -...
      8'h43: code = build_code(4, 5'b01010); // C -.-.
      8'h44: code = build_code(3, 5'b00100); // D -..
      8'h45: code = build_code(1, 5'b00000); // E .
      8'h46: code = build_code(4, 5'b00010); // F ..-.
      8'h47: code = build_code(3, 5'b00110); // G --.
      8'h48: code = build_code(4, 5'b00000); // H ....
      8'h49: code = build_code(2, 5'b00000); // I ..
      8'h4A: code = build_code(4, 5'b00111); // J .---
      8'h4B: code = build_code(3, 5'b00101); // K -.-
      8'h4C: code = build_code(4, 5'b00100); // L .-..
      8'h4D: code = build_code(2, 5'b00011); // M --
      8'h4E: code = build_code(2, 5'b00010); // N -.
      8'h4F: code = build_code(3, 5'b00111); // O ---
      8'h50: code = build_code(4, 5'b00110); // P .--.
      8'h51: code = build_code(4, 5'b01101); // Q --.-
      8'h52: code = build_code(3, 5'b00010); // R .-.
      8'h53: code = build_code(3, 5'b00000); // S ...
      8'h54: code = build_code(1, 5'b00001); // T -
      8'h55: code = build_code(3, 5'b00001); // U ..-
      8'h56: code = build_code(4, 5'b00001); // V ...-
      8'h57: code = build_code(3, 5'b00011); // W .--
      8'h58: code = build_code(4, 5'b01001); // X -..-
      8'h59: code = build_code(4, 5'b01011); // Y -.--
      8'h5A: code = build_code(4, 5'b01100); // Z --..
      default: code = CODE_INVALID;
    endcase
  end

endmodule

// File: rtl/morse_keyer.sv
// morse_keyer: buffers ASCII characters in a small FIFO and keys them out
// as timed Morse on key_out (dot 1 unit, dash 3, intra-character space 1,
// character gap 3, word gap 4 on top of the preceding character gap).
// Optional build macro MORSE_LOWERCASE_EN: when defined, a-z are folded to
// A-Z before lookup; otherwise lower-case characters are dropped as invalid.
module morse_keyer
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 4,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_ascii,
  output logic       key_out,
  output logic       busy,
  output logic       char_done,
  output logic       err_invalid
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int CNT_W  = $clog2(MAX_UNITS * UNIT_CYCLES + 1);

  // Final counter value of each timed interval
  localparam logic [CNT_W-1:0] DOT_LAST     = CNT_W'(DOT_UNITS * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DASH_LAST    = CNT_W'(DASH_UNITS * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SPACE_LAST   = CNT_W'(SPACE_UNITS * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CHARGAP_LAST = CNT_W'(CHARGAP_UNITS * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WORDGAP_LAST = CNT_W'(WORDGAP_UNITS * UNIT_CYCLES - 1);

  // One cycle before the end of a gap, so the registered pulse lands on the last cycle
  localparam logic [CNT_W-1:0] CHARGAP_PRE  = CNT_W'(CHARGAP_UNITS * UNIT_CYCLES - 2);
  localparam logic [CNT_W-1:0] WORDGAP_PRE  = CNT_W'(WORDGAP_UNITS * UNIT_CYCLES - 2);

  localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(FIFO_DEPTH);

  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [FCNT_W-1:0] fifo_count;
  logic              push;
  logic              pop;

  morse_state_e      state;
  logic [CNT_W-1:0]  unit_cnt;
  logic [9:0]        shreg;
  logic [2:0]        sym_cnt;
  logic [7:0]        char_reg;
  logic [7:0]        lut_char;
  logic [9:0]        lut_code;
  logic [CNT_W-1:0]  mark_last;

  assign in_ready = (fifo_count != FIFO_FULL);
  assign push     = in_valid && in_ready;
  assign pop      = (state == ST_IDLE) && (fifo_count != '0);
  assign busy     = (fifo_count != '0) || (state != ST_IDLE);

  // Dash marks run three units, everything else one
  assign mark_last = (shreg[1:0] == SYM_DASH) ? DASH_LAST : DOT_LAST;

`ifdef MORSE_LOWERCASE_EN
  assign lut_char = ((char_reg >= 8'h61) && (char_reg <= 8'h7A)) ? (char_reg - 8'h20) : char_reg;
`else
  assign lut_char = char_reg;
`endif

  morse_lut u_lut (
    .ascii (lut_char),
    .code  (lut_code)
  );

  // Character storage; contents need no reset because the count guards reads
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr] <= in_ascii;
    end
  end

  // FIFO pointers wrap naturally; full/empty comes only from the count
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + FCNT_W'(1);
        2'b01:   fifo_count <= fifo_count - FCNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Keying sequencer with registered key_out, char_done and err_invalid
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      unit_cnt    <= '0;
      shreg       <= '0;
      sym_cnt     <= '0;
      char_reg    <= '0;
      key_out     <= 1'b0;
      char_done   <= 1'b0;
      err_invalid <= 1'b0;
    end else begin
      char_done   <= 1'b0;
      err_invalid <= 1'b0;
      case (state)
        ST_IDLE: begin
          unit_cnt <= '0;
          if (pop) begin
            char_reg <= fifo_mem[rd_ptr];
            state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          unit_cnt <= '0;
          if (char_reg == ASCII_SPACE) begin
            state <= ST_WORDGAP;
          end else if (lut_code == CODE_INVALID) begin
            err_invalid <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            shreg   <= lut_code;
            sym_cnt <= '0;
            key_out <= 1'b1;
            state   <= ST_MARK;
          end
        end
        ST_MARK: begin
          if (unit_cnt == mark_last) begin
            unit_cnt <= '0;
            key_out  <= 1'b0;
            shreg    <= {SYM_END, shreg[9:2]};
            sym_cnt  <= sym_cnt + 3'd1;
            if ((shreg[3:2] == SYM_END) || (sym_cnt == 3'd4)) begin
              state <= ST_CHARGAP;
            end else begin
              state <= ST_SPACE;
            end
          end else begin
            unit_cnt <= unit_cnt + CNT_W'(1);
          end
        end
        ST_SPACE: begin
          if (unit_cnt == SPACE_LAST) begin
            unit_cnt <= '0;
            key_out  <= 1'b1;
            state    <= ST_MARK;
          end else begin
            unit_cnt <= unit_cnt + CNT_W'(1);
          end
        end
        ST_CHARGAP: begin
          if (unit_cnt == CHARGAP_PRE) begin
            char_done <= 1'b1;
          end
          if (unit_cnt == CHARGAP_LAST) begin
            unit_cnt <= '0;
            state    <= ST_IDLE;
          end else begin
            unit_cnt <= unit_cnt + CNT_W'(1);
          end
        end
        ST_WORDGAP: begin
          if (unit_cnt == WORDGAP_PRE) begin
            char_done <= 1'b1;
          end
          if (unit_cnt == WORDGAP_LAST) begin
            unit_cnt <= '0;
            state    <= ST_IDLE;
          end else begin
            unit_cnt <= unit_cnt + CNT_W'(1);
          end
        end
        default: begin
          unit_cnt <= '0;
          key_out  <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_morse_keyer.sv
// tb_morse_keyer: drives directed and random characters into morse_keyer
// and compares every output on every cycle against a timeline built from
// dot/dash pattern strings and the unit timing rules.
module tb_morse_keyer;

  localparam int UNIT  = 4;
  localparam int DEPTH = 4;
  localparam int MAXC  = 20000;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_ascii = 8'h00;
  logic       in_ready;
  logic       key_out;
  logic       busy;
  logic       char_done;
  logic       err_invalid;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit key_exp  [MAXC];
  bit done_exp [MAXC];
  bit err_exp  [MAXC];

  byte unsigned pend_q[$];
  int           next_free = 0;
  int           stim_q[$];
  int           wait_cnt = 0;
  bit           pending = 0;
  byte unsigned pend_char = 8'h00;

  morse_keyer #(.UNIT_CYCLES(UNIT), .FIFO_DEPTH(DEPTH)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_ascii    (in_ascii),
    .key_out     (key_out),
    .busy        (busy),
    .char_done   (char_done),
    .err_invalid (err_invalid)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Dot/dash text for a character; empty string means no Morse mapping
  function automatic string morsePattern(input byte unsigned ch);
    byte unsigned c;
    c = ch;
`ifdef MORSE_LOWERCASE_EN
    if (c >= 8'h61 && c <= 8'h7A) c = c - 8'd32;
`endif
    case (c)
      "0": return "-----";  "1": return ".----";  "2": return "..---";
      "3": return "...--";  "4": return "....-";  "5": return ".....";
      "6": return "-....";  "7": return "--...";  "8": return "---..";
      "9": return "----.";
      "A": return ".-";     "B": return "-...";   "C": return "-.-.";
      "D": return "-..";    "E": return ".";      "F": return "..-.";
      "G": return "--.";    "H": return "....";   "I": return "..";
      "J": return ".---";   "K": return "-.-";    "L": return ".-..";
      "M": return "--";     "N": return "-.";     "O": return "---";
      "P": return ".--.";   "Q": return "--.-";   "R": return ".-.";
      "S": return "...";    "T": return "-";      "U": return "..-";
      "V": return "...-";   "W": return ".--";    "X": return "-..-";
      "Y": return "-.--";   "Z": return "--..";
      default: return "";
    endcase
  endfunction

  // Lays out the expected waveform of a character popped in cycle p
  task automatic scheduleChar(input int p, input byte unsigned ch);
    string pat;
    int    t;
    t = p + 2;
    if (ch == 8'h20) begin
      done_exp[t + 4*UNIT - 1] = 1'b1;
      next_free = t + 4*UNIT;
    end else begin
      pat = morsePattern(ch);
      if (pat.len() == 0) begin
        err_exp[p + 2] = 1'b1;
        next_free = p + 2;
      end else begin
        for (int k = 0; k < pat.len(); k++) begin
          int len;
          len = (pat[k] == "-") ? 3*UNIT : UNIT;
          for (int j = 0; j < len; j++) key_exp[t + j] = 1'b1;
          t += len;
          if (k != pat.len() - 1) t += UNIT;
        end
        done_exp[t + 3*UNIT - 1] = 1'b1;
        next_free = t + 3*UNIT;
      end
    end
  endtask

  // Presents the next queued character (held until accepted) or idles
  task automatic applyStimulus();
    int item;
    if (!pending) begin
      if (wait_cnt > 0) begin
        wait_cnt--;
      end else if (stim_q.size() > 0) begin
        item = stim_q.pop_front();
        if (item >= 256) begin
          wait_cnt = item - 256;
        end else begin
          pending   = 1'b1;
          pend_char = item[7:0];
        end
      end
    end
    in_valid = pending;
    in_ascii = pending ? pend_char : 8'($urandom);
  endtask

  // One cycle: compare outputs, drive inputs, advance the reference model
  task automatic runCycle();
    bit do_pop;
    bit do_push;
    checkOutput("key_out",     key_out,     key_exp[cyc]);
    checkOutput("char_done",   char_done,   done_exp[cyc]);
    checkOutput("err_invalid", err_invalid, err_exp[cyc]);
    checkOutput("in_ready",    in_ready,    pend_q.size() < DEPTH);
    checkOutput("busy",        busy,        (pend_q.size() != 0) || (cyc < next_free));
    applyStimulus();
    do_pop  = (pend_q.size() > 0) && (cyc >= next_free);
    do_push = in_valid && (pend_q.size() < DEPTH);
    if (do_pop) scheduleChar(cyc, pend_q.pop_front());
    if (do_push) begin
      pend_q.push_back(in_ascii);
      pending = 1'b0;
    end
    cyc++;
  endtask

  initial begin
    int r;
    int w;

    resetn = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("rst_key_out",  key_out,     1'b0);
    checkOutput("rst_done",     char_done,   1'b0);
    checkOutput("rst_err",      err_invalid, 1'b0);
    checkOutput("rst_busy",     busy,        1'b0);
    checkOutput("rst_in_ready", in_ready,    1'b1);

    stim_q = '{"E", 256+40, "A", 256+60, "0", " ", 256+150, "#", 256+10,
               "0", "0", "0", "0", "0", "0", 256+10, "a", 256+50};
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: stim_q.push_back(int'("A") + $urandom_range(0, 25));
        3, 4:    stim_q.push_back(int'("0") + $urandom_range(0, 9));
        5:       stim_q.push_back(int'(" "));
        6:       stim_q.push_back(int'("a") + $urandom_range(0, 25));
        7:       stim_q.push_back($urandom_range(0, 255));
        8:       stim_q.push_back(int'("#"));
        default: stim_q.push_back(int'("A") + $urandom_range(0, 25));
      endcase
      if ($urandom_range(0, 9) < 3) stim_q.push_back(256 + $urandom_range(0, 25));
    end

    resetn = 1'b1;
    cyc = 0;
    while ((stim_q.size() > 0 || pending || wait_cnt > 0 || pend_q.size() > 0 ||
            cyc < next_free + 20) && cyc < MAXC - 1) begin
      runCycle();
      @(negedge clock);
    end
    in_valid = 1'b0;
    checkOutput("drain_in_time", cyc < MAXC - 1, 1'b1);

    // Reset in the middle of a dash with characters still queued
    in_valid = 1'b1;
    in_ascii = "0";
    repeat (3) @(negedge clock);
    in_valid = 1'b0;
    w = 0;
    while (!key_out && w < 50) begin
      @(negedge clock);
      w++;
    end
    checkOutput("mark_started", w < 50, 1'b1);
    repeat (6) @(negedge clock);
    checkOutput("mid_dash_key", key_out, 1'b1);
    checkOutput("mid_dash_busy", busy, 1'b1);
    #2 resetn = 1'b0;
    #1;
    checkOutput("async_rst_key",   key_out,     1'b0);
    checkOutput("async_rst_ready", in_ready,    1'b1);
    checkOutput("async_rst_busy",  busy,        1'b0);
    checkOutput("async_rst_done",  char_done,   1'b0);
    checkOutput("async_rst_err",   err_invalid, 1'b0);
    @(negedge clock);
    resetn = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      checkOutput("post_rst_key",  key_out, 1'b0);
      checkOutput("post_rst_busy", busy,    1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
